// File: rtl/upf_power_seq_ctrl.sv
// Power-state sequencer for one switchable domain: orders clock gating, isolation,
// retention and the power switch on the way down and back up, with a power-good timeout.
module upf_power_seq_ctrl #(
  parameter int ISO_DLY    = 2,
  parameter int RET_DLY    = 2,
  parameter int SW_DLY     = 4,
  parameter int PG_TIMEOUT = 16,
  parameter int CNT_W      = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SLEEP_REQ,
  input  logic       PWR_GOOD,
  output logic       CLK_EN,
  output logic       ISO,
  output logic       RET,
  output logic       PWR,
  output logic       SLEEP_ACK,
  output logic       ERR,
  output logic [3:0] STATE
);

  typedef enum logic [3:0] {
    S_ON      = 4'd0,
    S_CKOFF   = 4'd1,
    S_ISO_ON  = 4'd2,
    S_SAVE    = 4'd3,
    S_PDOWN   = 4'd4,
    S_OFF     = 4'd5,
    S_PUP     = 4'd6,
    S_RESTORE = 4'd7,
    S_ISO_OFF = 4'd8,
    S_ERR     = 4'd9
  } state_t;

  state_t           state_r;
  state_t           next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             timed_s;

  // Output vector {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} held while in each state.
  function automatic logic [5:0] state_outputs(input state_t s);
    logic [5:0] o;
    case (s)
      S_ON:      o = 6'b100100;
      S_CKOFF:   o = 6'b000100;
      S_ISO_ON:  o = 6'b010100;
      S_SAVE:    o = 6'b011100;
      S_PDOWN:   o = 6'b011000;
      S_OFF:     o = 6'b011010;
      S_PUP:     o = 6'b011110;
      S_RESTORE: o = 6'b010110;
      S_ISO_OFF: o = 6'b000110;
      S_ERR:     o = 6'b011011;
      default:   o = 6'b100100;
    endcase
    return o;
  endfunction

  // Next-state selection; request changes are only honoured in the stable ON/OFF/ERR states.
  always_comb begin
    next_s  = state_r;
    timed_s = 1'b0;
    case (state_r)
      S_ON: begin
        if (SLEEP_REQ) next_s = S_CKOFF;
        else           next_s = S_ON;
      end
      S_CKOFF: next_s = S_ISO_ON;
      S_ISO_ON: begin
        timed_s = 1'b1;
        if (cnt_r == CNT_W'(ISO_DLY - 1)) next_s = S_SAVE;
        else                              next_s = S_ISO_ON;
      end
      S_SAVE: begin
        timed_s = 1'b1;
        if (cnt_r == CNT_W'(RET_DLY - 1)) next_s = S_PDOWN;
        else                              next_s = S_SAVE;
      end
      S_PDOWN: begin
        timed_s = 1'b1;
        if (cnt_r == CNT_W'(SW_DLY - 1)) next_s = S_OFF;
        else                             next_s = S_PDOWN;
      end
      S_OFF: begin
        if (!SLEEP_REQ) next_s = S_PUP;
        else            next_s = S_OFF;
      end
      S_PUP: begin
        timed_s = 1'b1;
        // A late power-good on the final timeout cycle still wins over the error.
        if (PWR_GOOD)                              next_s = S_RESTORE;
        else if (cnt_r == CNT_W'(PG_TIMEOUT - 1)) next_s = S_ERR;
        else                                       next_s = S_PUP;
      end
      S_RESTORE: begin
        timed_s = 1'b1;
        if (cnt_r == CNT_W'(RET_DLY - 1)) next_s = S_ISO_OFF;
        else                              next_s = S_RESTORE;
      end
      S_ISO_OFF: begin
        timed_s = 1'b1;
        if (cnt_r == CNT_W'(ISO_DLY - 1)) next_s = S_ON;
        else                              next_s = S_ISO_OFF;
      end
      S_ERR: begin
        if (SLEEP_REQ) next_s = S_OFF;
        else           next_s = S_ERR;
      end
      default: next_s = S_ON;
    endcase
  end

  // State, phase counter and registered controls; outputs change on the edge entering a state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= S_ON;
      cnt_r   <= {CNT_W{1'b0}};
      {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} <= 6'b100100;
    end else begin
      state_r <= next_s;
      if ((next_s != state_r) || !timed_s) cnt_r <= {CNT_W{1'b0}};
      else                                 cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} <= state_outputs(next_s);
    end
  end

  assign STATE = state_r;

endmodule

// File: tb/tb_upf_power_seq_ctrl.sv
// Directed bench for upf_power_seq_ctrl with default parameters; outputs are compared
// as {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} plus STATE, one edge at a time.
module tb_upf_power_seq_ctrl;

  logic       CLK;
  logic       RESET;
  logic       SLEEP_REQ;
  logic       PWR_GOOD;
  logic       CLK_EN;
  logic       ISO;
  logic       RET;
  logic       PWR;
  logic       SLEEP_ACK;
  logic       ERR;
  logic [3:0] STATE;

  int vectors;
  int miscompares;

  upf_power_seq_ctrl dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .SLEEP_REQ (SLEEP_REQ),
    .PWR_GOOD  (PWR_GOOD),
    .CLK_EN    (CLK_EN),
    .ISO       (ISO),
    .RET       (RET),
    .PWR       (PWR),
    .SLEEP_ACK (SLEEP_ACK),
    .ERR       (ERR),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  // Advance one edge, settle, and check the safety invariants on the new outputs.
  task automatic tick();
    logic ok;
    @(posedge CLK);
    #1;
    ok = 1'b1;
    if (!PWR && !(RET && ISO && !CLK_EN)) ok = 1'b0;
    if (RET && !ISO) ok = 1'b0;
    if (ISO && CLK_EN) ok = 1'b0;
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL invariant at %0t: CLK_EN=%b ISO=%b RET=%b PWR=%b", $time, CLK_EN, ISO, RET, PWR);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; SLEEP_REQ = 1'b0; PWR_GOOD = 1'b0;
    #12;
    vectors++;
    if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b100100 || STATE !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_values: got outs=%b state=%0d expected outs=100100 state=0",
               {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b100100 || STATE !== 4'd0) begin
        miscompares++;
        $display("FAIL stay_on cycle %0d: got outs=%b state=%0d expected outs=100100 state=0",
                 i, {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
      end
    end
  endtask

  task automatic test_power_down();
    logic [5:0] exp_o [10];
    logic [3:0] exp_s [10];
    exp_o = '{6'b000100, 6'b010100, 6'b010100, 6'b011100, 6'b011100,
              6'b011000, 6'b011000, 6'b011000, 6'b011000, 6'b011010};
    exp_s = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5};
    SLEEP_REQ = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      vectors++;
      if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== exp_o[e] || STATE !== exp_s[e]) begin
        miscompares++;
        $display("FAIL power_down e%0d: got outs=%b state=%0d expected outs=%b state=%0d",
                 e, {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE, exp_o[e], exp_s[e]);
      end
    end
  endtask

  task automatic test_power_up();
    logic [5:0] exp_o [8];
    logic [3:0] exp_s [8];
    exp_o = '{6'b011110, 6'b011110, 6'b011110, 6'b010110, 6'b010110,
              6'b000110, 6'b000110, 6'b100100};
    exp_s = '{4'd6, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8, 4'd8, 4'd0};
    SLEEP_REQ = 1'b0; PWR_GOOD = 1'b0;
    for (int u = 0; u < 8; u++) begin
      tick();
      // Power good becomes visible on the third edge after PWR rises.
      if (u == 2) PWR_GOOD = 1'b1;
      vectors++;
      if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== exp_o[u] || STATE !== exp_s[u]) begin
        miscompares++;
        $display("FAIL power_up u%0d: got outs=%b state=%0d expected outs=%b state=%0d",
                 u, {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE, exp_o[u], exp_s[u]);
      end
    end
    PWR_GOOD = 1'b0;
  endtask

  task automatic test_pg_timeout();
    SLEEP_REQ = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if (STATE !== 4'd5) begin
      miscompares++;
      $display("FAIL timeout_setup_off: got state=%0d expected state=5", STATE);
    end
    SLEEP_REQ = 1'b0; PWR_GOOD = 1'b0;
    for (int u = 0; u < 16; u++) begin
      tick();
      vectors++;
      if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b011110 || STATE !== 4'd6) begin
        miscompares++;
        $display("FAIL pup_wait u%0d: got outs=%b state=%0d expected outs=011110 state=6",
                 u, {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
      end
    end
    tick();
    vectors++;
    if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b011011 || STATE !== 4'd9) begin
      miscompares++;
      $display("FAIL timeout_err: got outs=%b state=%0d expected outs=011011 state=9",
               {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
    end
    PWR_GOOD = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b011011 || STATE !== 4'd9) begin
      miscompares++;
      $display("FAIL err_hold: got outs=%b state=%0d expected outs=011011 state=9",
               {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
    end
    PWR_GOOD = 1'b0;
    SLEEP_REQ = 1'b1;
    tick();
    vectors++;
    if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b011010 || STATE !== 4'd5) begin
      miscompares++;
      $display("FAIL err_to_off: got outs=%b state=%0d expected outs=011010 state=5",
               {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
    end
    // Recover with power good already present: PUP, RESTORE, 2+2 cycles to ON.
    SLEEP_REQ = 1'b0; PWR_GOOD = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b100100 || STATE !== 4'd0) begin
      miscompares++;
      $display("FAIL err_recover_on: got outs=%b state=%0d expected outs=100100 state=0",
               {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
    end
  endtask

  task automatic test_back_to_back();
    PWR_GOOD = 1'b1;
    SLEEP_REQ = 1'b1;
    tick();
    SLEEP_REQ = 1'b0;
    vectors++;
    if (STATE !== 4'd1 || CLK_EN !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_ckoff: got state=%0d clk_en=%b expected state=1 clk_en=0", STATE, CLK_EN);
    end
    for (int i = 1; i < 9; i++) tick();
    vectors++;
    if (STATE !== 4'd4 || SLEEP_ACK !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_pdown_e8: got state=%0d ack=%b expected state=4 ack=0", STATE, SLEEP_ACK);
    end
    tick();
    vectors++;
    if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b011010 || STATE !== 4'd5) begin
      miscompares++;
      $display("FAIL pulse_off_e9: got outs=%b state=%0d expected outs=011010 state=5",
               {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
    end
    tick();
    vectors++;
    if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b011110 || STATE !== 4'd6) begin
      miscompares++;
      $display("FAIL pulse_pup_e10: got outs=%b state=%0d expected outs=011110 state=6",
               {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
    end
    for (int i = 11; i < 15; i++) tick();
    vectors++;
    if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b000110 || STATE !== 4'd8) begin
      miscompares++;
      $display("FAIL pulse_iso_off_e14: got outs=%b state=%0d expected outs=000110 state=8",
               {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
    end
    tick();
    vectors++;
    if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b100100 || STATE !== 4'd0) begin
      miscompares++;
      $display("FAIL pulse_on_e15: got outs=%b state=%0d expected outs=100100 state=0",
               {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
    end
    PWR_GOOD = 1'b0;
  endtask

  task automatic test_reset_mid_sequence();
    SLEEP_REQ = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b011100 || STATE !== 4'd3) begin
      miscompares++;
      $display("FAIL save_reached: got outs=%b state=%0d expected outs=011100 state=3",
               {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
    end
    #2;
    RESET = 1'b0;
    #1;
    vectors++;
    if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b100100 || STATE !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset: got outs=%b state=%0d expected outs=100100 state=0",
               {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
    end
    SLEEP_REQ = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if ({CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR} !== 6'b100100 || STATE !== 4'd0) begin
      miscompares++;
      $display("FAIL after_reset_on: got outs=%b state=%0d expected outs=100100 state=0",
               {CLK_EN, ISO, RET, PWR, SLEEP_ACK, ERR}, STATE);
    end
  endtask

  initial begin
    CLK = 1'b0;
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_power_down();
    test_power_up();
    test_pg_timeout();
    test_back_to_back();
    test_reset_mid_sequence();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
